spartan_bus_arb: RTL and testbench
==================================

Name: spartan_bus_arb

Overview:
- Round-robin, packet-locked arbiter that shares one spartan bus stream sink between NUM_PORTS requesters.
- Typical sink: the async FIFO input toward another clock domain.
- Each requester presents a VAL/RDY stream with a LAST flag. The arbiter grants one port at a time and holds the grant until that port's LAST beat is accepted.
- The muxed stream goes through a one-entry registered output stage, tagged with the source port ID.

Parameters:
- NUM_PORTS, 4, number of requesters; range 2..16, need not be a power of 2.
- ID_WIDTH, 2, width of DOUT_ID; 2**ID_WIDTH >= NUM_PORTS is required.
- DATA_WIDTH, 32, payload width per beat.

Ports:
- CLK  in  1  single clock for the whole block.
- RST_N  in  1  asynchronous active-low reset.
- DIN  in  NUM_PORTS*DATA_WIDTH  requester payloads; port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- DIN_LAST  in  NUM_PORTS  last beat of packet, one bit per port.
- DIN_VAL  in  NUM_PORTS  beat valid, one bit per port.
- DIN_RDY  out  NUM_PORTS  beat accepted, one bit per port.
- DOUT  out  DATA_WIDTH  registered payload.
- DOUT_LAST  out  1  registered last flag.
- DOUT_ID  out  ID_WIDTH  source port index of the current DOUT beat.
- DOUT_VAL  out  1  output beat valid.
- DOUT_RDY  in  1  sink ready.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, grant=0, rr_ptr=0, DOUT_VAL=0, DOUT/DOUT_LAST/DOUT_ID=0, DIN_RDY=all 0.
- Transfer rules:
  - A beat transfers on a port when VAL&&RDY at a rising CLK edge.
  - VAL must not depend on RDY.
- State IDLE:
  - DIN_RDY=0 on all ports.
  - If any DIN_VAL bit is set, pick the first set bit searching upward from rr_ptr, wrapping NUM_PORTS-1 -> 0.
  - On the next edge: grant <= pick, state <= BUSY.
  - Other DIN_VAL bits are ignored until the next arbitration.
  - No DIN_VAL set: stay IDLE.
- State BUSY:
  - DIN_RDY[grant] = (!DOUT_VAL || DOUT_RDY). All other DIN_RDY bits are 0.
  - On an accepted beat: DOUT <= DIN[grant], DOUT_LAST <= DIN_LAST[grant], DOUT_ID <= grant, DOUT_VAL <= 1.
  - Accepted beat with LAST=1: state <= IDLE, rr_ptr <= (grant==NUM_PORTS-1) ? 0 : grant+1.
  - Granted port drops DIN_VAL mid-packet: grant is held and the stream stalls. No timeout, no preemption.
- Output stage:
  - DOUT_VAL clears on DOUT_RDY when no new beat is accepted in the same cycle.
  - Accept and drain in the same cycle keeps DOUT_VAL=1 with the new data, giving full throughput.
  - DOUT* holds stable while DOUT_VAL && !DOUT_RDY.
- Latency and throughput:
  - First DIN_VAL to first DIN_RDY: 1 cycle (arbitration cycle).
  - Accepted beat to DOUT_VAL: 1 cycle.
  - Within a packet: 1 beat/cycle.
  - Between packets: exactly one IDLE bubble cycle on the input side. The output stage may still be draining during it.
- Single-beat packet (LAST on the first beat): BUSY for that cycle only, then IDLE.
- Fairness: with all ports continuously requesting, grants go 0,1,2,...,NUM_PORTS-1,0,...
- Reset asserted mid-packet:
  - All state clears immediately.
  - The in-flight DOUT beat is discarded and the partial packet is not completed.
  - After deassertion, arbitration restarts from port 0.
- Grant-index width: grant and rr_ptr are ID_WIDTH bits. Values >= NUM_PORTS are unreachable.

Decomposition:
- Shared include spartan_bus_defs.vh:
  - state encodings SPARTAN_ARB_IDLE=1'b0, SPARTAN_ARB_BUSY=1'b1;
  - localparam for the bus LAST-flag convention.
- Sub-module spartan_arb_pick: combinational rotating priority picker.
  - Inputs: req[NUM_PORTS], start[ID_WIDTH].
  - Outputs: any, idx[ID_WIDTH].
  - Instanced once; the top owns all registers.

Test Plan:
- Reset: hold RST_N=0 with DIN_VAL=4'b1111 -> DIN_RDY=0, DOUT_VAL=0 throughout. After release, the first grant goes to port 0, one cycle later.
- Single requester: port 2 sends a 3-beat packet 0xA1,0xA2,0xA3 (LAST on the 3rd) with DOUT_RDY=1 -> DIN_RDY[2] high for 3 consecutive cycles; DOUT shows 0xA1..0xA3 with DOUT_ID=2 one cycle later; DOUT_LAST=1 on 0xA3 only.
- Round robin: all 4 ports continuously send 1-beat packets (data = 0x10+port) -> DOUT_ID sequence 0,1,2,3,0,1; one bubble cycle between grants; no port starves.
- Backpressure: DOUT_RDY=0 for 5 cycles mid-packet on port 1 -> DOUT holds its value; DIN_RDY[1]=0 after the output register fills; no beat lost or duplicated when DOUT_RDY returns.
- Lock: port 3 drops DIN_VAL for 4 cycles mid-packet while port 0 requests -> port 0 receives no DIN_RDY until port 3's LAST is accepted; port 0 is granted next.
- Mid-packet reset: RST_N pulsed low during beat 2 of a port-1 packet -> DOUT_VAL=0 immediately; the next packet after release is granted to the lowest requesting port starting at 0.

Source files
------------

// File: rtl/spartan_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spartan_bus_arb_pkg
// Description : Shared arbiter state encodings and spartan bus flag levels.
// Revision    : 1.0 - initial release
// ============================================================================
package spartan_bus_arb_pkg;

    typedef enum logic [0:0] {
        SPARTAN_ARB_IDLE = 1'b0,
        SPARTAN_ARB_BUSY = 1'b1
    } arb_state_t;

    // Level of the LAST flag that closes a packet on the spartan bus
    localparam logic c_BUS_LAST_ASSERTED = 1'b1;

endpackage : spartan_bus_arb_pkg
`default_nettype wire

// File: rtl/spartan_bus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : spartan_arb_pick
// Description : Combinational rotating-priority picker; first set req bit at
//               or above start, wrapping NUM_PORTS-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spartan_arb_pick #(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [ID_WIDTH-1:0]  start,
    output logic                 any,
    output logic [ID_WIDTH-1:0]  idx
);

    localparam int                c_SW = ID_WIDTH + 1;
    localparam logic [c_SW-1:0]   c_NP = c_SW'(NUM_PORTS);

    logic [ID_WIDTH-1:0]    w_start;
    logic [2*NUM_PORTS-1:0] w_dbl;
    logic [c_SW-1:0]        w_sum;

    // Out-of-range start values are unreachable; fold them to 0 for safety
    assign w_start = ({1'b0, start} < c_NP) ? start : '0;

    always_comb begin
        w_dbl = {req, req} >> w_start;
        any   = 1'b0;
        idx   = '0;
        w_sum = '0;
        // Descending scan so the smallest rotated offset wins
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (w_dbl[k]) begin
                w_sum = {1'b0, w_start} + c_SW'(k);
                if (w_sum >= c_NP) begin
                    w_sum = w_sum - c_NP;
                end
                idx = w_sum[ID_WIDTH-1:0];
                any = 1'b1;
            end
        end
    end

endmodule : spartan_arb_pick
`default_nettype wire

// File: rtl/spartan_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : spartan_bus_arb
// Description : Round-robin, packet-locked arbiter sharing one spartan bus
//               sink between NUM_PORTS requesters via a registered stage.
// Revision    : 1.0 - initial release
// ============================================================================
module spartan_bus_arb
    import spartan_bus_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] DIN,
    input  logic [NUM_PORTS-1:0]            DIN_LAST,
    input  logic [NUM_PORTS-1:0]            DIN_VAL,
    output logic [NUM_PORTS-1:0]            DIN_RDY,
    output logic [DATA_WIDTH-1:0]           DOUT,
    output logic                            DOUT_LAST,
    output logic [ID_WIDTH-1:0]             DOUT_ID,
    output logic                            DOUT_VAL,
    input  logic                            DOUT_RDY
);

    localparam logic [ID_WIDTH-1:0] c_LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

    arb_state_t             r_state;
    logic [ID_WIDTH-1:0]    r_grant;
    logic [ID_WIDTH-1:0]    r_rr_ptr;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_dout_last;
    logic [ID_WIDTH-1:0]    r_dout_id;
    logic                   r_dout_val;

    logic                   w_pick_any;
    logic [ID_WIDTH-1:0]    w_pick_idx;
    logic                   w_slot_free;
    logic                   w_sel_val;
    logic                   w_sel_last;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [NUM_PORTS-1:0]   w_din_rdy;
    logic                   w_accept;

    spartan_arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .ID_WIDTH  (ID_WIDTH)
    ) u_pick (
        .req   (DIN_VAL),
        .start (r_rr_ptr),
        .any   (w_pick_any),
        .idx   (w_pick_idx)
    );

    // Output register can take a beat when empty or draining this cycle
    assign w_slot_free = !r_dout_val || DOUT_RDY;

    always_comb begin
        w_sel_val  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        w_din_rdy  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant == ID_WIDTH'(p)) begin
                w_sel_val    = DIN_VAL[p];
                w_sel_last   = DIN_LAST[p];
                w_sel_data   = DIN[p*DATA_WIDTH +: DATA_WIDTH];
                w_din_rdy[p] = (r_state == SPARTAN_ARB_BUSY) && w_slot_free;
            end
        end
    end

    assign w_accept = (r_state == SPARTAN_ARB_BUSY) && w_sel_val && w_slot_free;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= SPARTAN_ARB_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_dout      <= '0;
            r_dout_last <= 1'b0;
            r_dout_id   <= '0;
            r_dout_val  <= 1'b0;
        end else begin
            case (r_state)
                SPARTAN_ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick_idx;
                        r_state <= SPARTAN_ARB_BUSY;
                    end
                end
                SPARTAN_ARB_BUSY: begin
                    if (w_accept && (w_sel_last == c_BUS_LAST_ASSERTED)) begin
                        r_state  <= SPARTAN_ARB_IDLE;
                        r_rr_ptr <= (r_grant == c_LAST_PORT) ? '0 : r_grant + 1'b1;
                    end
                end
                default: r_state <= SPARTAN_ARB_IDLE;
            endcase

            if (w_accept) begin
                r_dout      <= w_sel_data;
                r_dout_last <= w_sel_last;
                r_dout_id   <= r_grant;
                r_dout_val  <= 1'b1;
            end else if (DOUT_RDY) begin
                r_dout_val  <= 1'b0;
            end
        end
    end

    assign DIN_RDY   = w_din_rdy;
    assign DOUT      = r_dout;
    assign DOUT_LAST = r_dout_last;
    assign DOUT_ID   = r_dout_id;
    assign DOUT_VAL  = r_dout_val;

endmodule : spartan_bus_arb
`default_nettype wire

// File: tb/tb_spartan_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_spartan_bus_arb
// Description : Directed self-checking bench for spartan_bus_arb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spartan_bus_arb;

    localparam int NUM_PORTS  = 4;
    localparam int ID_WIDTH   = 2;
    localparam int DATA_WIDTH = 32;

    logic                            CLK;
    logic                            RST_N;
    logic [NUM_PORTS*DATA_WIDTH-1:0] DIN;
    logic [NUM_PORTS-1:0]            DIN_LAST;
    logic [NUM_PORTS-1:0]            DIN_VAL;
    logic [NUM_PORTS-1:0]            DIN_RDY;
    logic [DATA_WIDTH-1:0]           DOUT;
    logic                            DOUT_LAST;
    logic [ID_WIDTH-1:0]             DOUT_ID;
    logic                            DOUT_VAL;
    logic                            DOUT_RDY;

    int n_chk;
    int n_err;

    spartan_bus_arb #(
        .NUM_PORTS  (NUM_PORTS),
        .ID_WIDTH   (ID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_LAST  (DIN_LAST),
        .DIN_VAL   (DIN_VAL),
        .DIN_RDY   (DIN_RDY),
        .DOUT      (DOUT),
        .DOUT_LAST (DOUT_LAST),
        .DOUT_ID   (DOUT_ID),
        .DOUT_VAL  (DOUT_VAL),
        .DOUT_RDY  (DOUT_RDY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_port(input int p, input logic v, input logic l, input logic [31:0] d);
        DIN_VAL[p]                      = v;
        DIN_LAST[p]                     = l;
        DIN[p*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    task automatic check_out(input string tag, input logic [31:0] d, input logic [1:0] id,
                             input logic l);
        check({tag, "_val"},  64'(DOUT_VAL),  64'd1);
        check({tag, "_data"}, 64'(DOUT),      64'(d));
        check({tag, "_id"},   64'(DOUT_ID),   64'(id));
        check({tag, "_last"}, 64'(DOUT_LAST), 64'(l));
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        RST_N    = 1'b0;
        DIN      = '0;
        DIN_LAST = '0;
        DIN_VAL  = '0;
        DOUT_RDY = 1'b1;

        // Reset held with every port requesting: nothing may be accepted
        for (int p = 0; p < NUM_PORTS; p++) set_port(p, 1'b1, 1'b1, 32'h10 + p);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            check("rst_rdy",  64'(DIN_RDY),  64'h0);
            check("rst_dval", 64'(DOUT_VAL), 64'h0);
        end
        check("rst_dout", 64'(DOUT), 64'h0);
        check("rst_id",   64'(DOUT_ID), 64'h0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK); #1;
        check("arb_cycle_rdy", 64'(DIN_RDY), 64'h0);

        // Round robin of single-beat packets, one idle bubble between grants
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK); #1;
            check($sformatf("rr%0d_rdy", k), 64'(DIN_RDY), 64'(4'b0001 << (k % 4)));
            @(negedge CLK);
            if (k == 7) DIN_VAL = '0;
            #1;
            check($sformatf("rr%0d_bubble", k), 64'(DIN_RDY), 64'h0);
            check_out($sformatf("rr%0d", k), 32'h10 + (k % 4), 2'(k % 4), 1'b1);
        end

        // Single requester: port 2, three beats
        @(negedge CLK);
        set_port(2, 1'b1, 1'b0, 32'hA1); #1;
        check("p2_arb_rdy", 64'(DIN_RDY), 64'h0);
        @(negedge CLK); #1;
        check("p2_b1_rdy", 64'(DIN_RDY), 64'b0100);
        @(negedge CLK);
        set_port(2, 1'b1, 1'b0, 32'hA2); #1;
        check("p2_b2_rdy", 64'(DIN_RDY), 64'b0100);
        check_out("p2_o1", 32'hA1, 2'd2, 1'b0);
        @(negedge CLK);
        set_port(2, 1'b1, 1'b1, 32'hA3); #1;
        check("p2_b3_rdy", 64'(DIN_RDY), 64'b0100);
        check_out("p2_o2", 32'hA2, 2'd2, 1'b0);
        @(negedge CLK);
        set_port(2, 1'b0, 1'b0, 32'h0); #1;
        check("p2_done_rdy", 64'(DIN_RDY), 64'h0);
        check_out("p2_o3", 32'hA3, 2'd2, 1'b1);
        @(negedge CLK); #1;
        check("p2_drained", 64'(DOUT_VAL), 64'h0);

        // Backpressure on port 1: sink stalls 5 cycles after first beat
        @(negedge CLK);
        set_port(1, 1'b1, 1'b0, 32'hB0); #1;
        @(negedge CLK); #1;
        check("bp_b0_rdy", 64'(DIN_RDY), 64'b0010);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            set_port(1, 1'b1, 1'b0, 32'hB1);
            DOUT_RDY = 1'b0; #1;
            check($sformatf("bp_stall%0d_rdy", i), 64'(DIN_RDY), 64'h0);
            check_out($sformatf("bp_stall%0d", i), 32'hB0, 2'd1, 1'b0);
        end
        @(negedge CLK);
        DOUT_RDY = 1'b1; #1;
        check("bp_resume_rdy", 64'(DIN_RDY), 64'b0010);
        check_out("bp_hold", 32'hB0, 2'd1, 1'b0);
        @(negedge CLK);
        set_port(1, 1'b1, 1'b0, 32'hB2); #1;
        check_out("bp_o1", 32'hB1, 2'd1, 1'b0);
        @(negedge CLK);
        set_port(1, 1'b1, 1'b1, 32'hB3); #1;
        check_out("bp_o2", 32'hB2, 2'd1, 1'b0);
        @(negedge CLK);
        set_port(1, 1'b0, 1'b0, 32'h0); #1;
        check_out("bp_o3", 32'hB3, 2'd1, 1'b1);

        // Lock: port 3 pauses mid-packet while port 0 waits
        @(negedge CLK);
        set_port(3, 1'b1, 1'b0, 32'hC0);
        set_port(0, 1'b1, 1'b1, 32'hD0); #1;
        @(negedge CLK); #1;
        check("lk_c0_rdy", 64'(DIN_RDY), 64'b1000);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            set_port(3, 1'b0, 1'b0, 32'hC1); #1;
            check($sformatf("lk_gap%0d_rdy", i), 64'(DIN_RDY), 64'b1000);
            check($sformatf("lk_gap%0d_dval", i), 64'(DOUT_VAL), 64'(i == 0));
        end
        @(negedge CLK);
        set_port(3, 1'b1, 1'b0, 32'hC1); #1;
        check("lk_c1_rdy", 64'(DIN_RDY), 64'b1000);
        @(negedge CLK);
        set_port(3, 1'b1, 1'b1, 32'hC2); #1;
        check_out("lk_o1", 32'hC1, 2'd3, 1'b0);
        @(negedge CLK);
        set_port(3, 1'b0, 1'b0, 32'h0); #1;
        check("lk_bubble_rdy", 64'(DIN_RDY), 64'h0);
        check_out("lk_o2", 32'hC2, 2'd3, 1'b1);
        @(negedge CLK); #1;
        check("lk_p0_rdy", 64'(DIN_RDY), 64'b0001);
        @(negedge CLK);
        set_port(0, 1'b0, 1'b0, 32'h0); #1;
        check_out("lk_o3", 32'hD0, 2'd0, 1'b1);

        // Reset pulsed during the second beat of a port 1 packet
        @(negedge CLK);
        set_port(1, 1'b1, 1'b0, 32'hE0); #1;
        @(negedge CLK); #1;
        check("mr_e0_rdy", 64'(DIN_RDY), 64'b0010);
        @(negedge CLK);
        set_port(1, 1'b1, 1'b0, 32'hE1); #1;
        check_out("mr_o1", 32'hE0, 2'd1, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        check("mr_dval", 64'(DOUT_VAL), 64'h0);
        check("mr_rdy",  64'(DIN_RDY),  64'h0);
        check("mr_dout", 64'(DOUT),     64'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        set_port(1, 1'b0, 1'b0, 32'h0);
        set_port(3, 1'b1, 1'b1, 32'h30);
        set_port(0, 1'b1, 1'b1, 32'hF0); #1;
        check("mr_arb_rdy",  64'(DIN_RDY),  64'h0);
        check("mr_arb_dval", 64'(DOUT_VAL), 64'h0);
        @(negedge CLK); #1;
        check("mr_regrant_rdy", 64'(DIN_RDY), 64'b0001);
        @(negedge CLK);
        DIN_VAL = '0; #1;
        check_out("mr_o2", 32'hF0, 2'd0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule : tb_spartan_bus_arb
`default_nettype wire
